// File: rtl/poly_mod_sub_seq.sv
// Streams out[i] = (A[i] - B[i]) mod q over a polynomial held in 1-cycle-latency RAMs,
// writing results through a 2-entry buffer to a destination port that may stall.
module poly_mod_sub_seq #(
  parameter int BIT_WIDTH  = 54,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic [BIT_WIDTH-1:0]  q,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BIT_WIDTH-1:0]  a_rdata,
  input  logic [BIT_WIDTH-1:0]  b_rdata,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [BIT_WIDTH-1:0]  wr_data,
  input  logic                  wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZERO,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LenOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [ADDR_WIDTH-1:0] r_rdAddr;
  logic [ADDR_WIDTH-1:0] r_wrAddr;
  logic [BIT_WIDTH-1:0]  r_q;
  logic [1:0]            r_credits;
  logic                  r_inFlight;
  logic [BIT_WIDTH-1:0]  r_fifo [2];
  logic                  r_head;
  logic                  r_tail;
  logic [1:0]            r_count;

  logic                  w_xfer;
  logic                  w_rdEn;
  logic                  w_launch;
  logic [BIT_WIDTH-1:0]  w_diff;
  logic [BIT_WIDTH-1:0]  w_result;
  logic [1:0]            w_creditsNext;

  assign w_xfer   = wr_en & wr_ready;
  assign w_rdEn   = (r_state == S_RUN) && ((r_credits != 2'd0) || w_xfer);
  assign w_launch = (r_state == S_IDLE) && start;

  // Operands are already reduced below q, so a single conditional add of q suffices.
  assign w_diff   = a_rdata - b_rdata;
  assign w_result = (a_rdata >= b_rdata) ? w_diff : w_diff + r_q;

  // Credits track results issued but not yet written; back at 2 means nothing left in flight.
  assign w_creditsNext = r_credits - {1'b0, w_rdEn} + {1'b0, w_xfer};

  assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done    = (r_state == S_FIN);
  assign rd_en   = w_rdEn;
  assign rd_addr = r_rdAddr;
  assign wr_en   = (r_count != 2'd0);
  assign wr_addr = r_wrAddr;
  assign wr_data = r_fifo[r_head];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (len == '0) ? S_ZERO : S_RUN;
      S_ZERO:  w_next = S_FIN;
      S_RUN:   if (w_rdEn && (r_remaining == LenOne)) w_next = S_DRAIN;
      S_DRAIN: if (w_creditsNext == 2'd2) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_rdAddr    <= '0;
      r_wrAddr    <= '0;
      r_q         <= '0;
      r_credits   <= 2'd0;
      r_inFlight  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inFlight <= w_rdEn;
      if (w_launch) begin
        r_remaining <= len;
        r_rdAddr    <= src_base;
        r_wrAddr    <= dst_base;
        r_q         <= q;
        r_credits   <= 2'd2;
      end else begin
        r_credits <= w_creditsNext;
        if (w_rdEn) begin
          r_remaining <= r_remaining - LenOne;
          r_rdAddr    <= r_rdAddr + AddrOne;
        end
        if (w_xfer) r_wrAddr <= r_wrAddr + AddrOne;
      end
    end
  end

  // Read data is only valid the cycle after rd_en, so it is captured from r_inFlight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (r_inFlight) begin
        r_fifo[r_tail] <= w_result;
        r_tail         <= ~r_tail;
      end
      if (w_xfer) r_head <= ~r_head;
      r_count <= r_count + {1'b0, r_inFlight} - {1'b0, w_xfer};
    end
  end

endmodule
